// File: rtl/line_buffer_ctrl_if.sv
// Pixel stream, line-buffer bus and window output of the line-buffer front end.
// The slave modport is the controller view; master is the upstream/line-buffer side.
interface line_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LB     = 4
) ();
  logic                           i_pixel_valid;
  logic [DATA_WIDTH-1:0]          i_pixel_data;
  logic                           o_ready;
  logic [NUM_LB-1:0]              o_lb_wren;
  logic [DATA_WIDTH-1:0]          o_lb_wdata;
  logic [NUM_LB-1:0]              o_lb_rden;
  logic [NUM_LB*3*DATA_WIDTH-1:0] i_lb_rdata;
  logic [9*DATA_WIDTH-1:0]        o_window;
  logic                           o_window_valid;
  logic                           o_intr;
  logic                           o_overflow;

  modport master (
    output i_pixel_valid, i_pixel_data, i_lb_rdata,
    input  o_ready, o_lb_wren, o_lb_wdata, o_lb_rden,
    input  o_window, o_window_valid, o_intr, o_overflow
  );

  modport slave (
    input  i_pixel_valid, i_pixel_data, i_lb_rdata,
    output o_ready, o_lb_wren, o_lb_wdata, o_lb_rden,
    output o_window, o_window_valid, o_intr, o_overflow
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Writes the pixel stream row by row into four rotating line buffers and, once three rows
// are held, reads three of them in lockstep to produce a registered 3x3 window.
module line_buffer_ctrl #(
  parameter int RL         = 640,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LB     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  line_buffer_ctrl_if.slave bus
);

  localparam int CNT_W  = (RL > 1) ? $clog2(RL) : 1;
  localparam int FILL_W = $clog2(4 * RL + 1);
  localparam int ROW_W  = 3 * DATA_WIDTH;
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(RL - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(4 * RL);
  localparam logic [FILL_W-1:0] FILL_READ = FILL_W'(3 * RL);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  // The one buffer not being read is the one just before rd_sel.
  function automatic logic [NUM_LB-1:0] rd_mask(input logic [1:0] sel);
    rd_mask = ~(NUM_LB'(1) << (sel - 2'd1));
  endfunction

  state_t                state_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic [1:0]            wr_sel_q;
  logic [1:0]            rd_sel_q;
  logic [1:0]            rd_sel_dly_q;
  logic [FILL_W-1:0]     fill_q;
  logic [FILL_W-1:0]     fill_d;
  logic [NUM_LB-1:0]     rden_q;
  logic                  intr_q;
  logic                  ovf_q;
  logic                  vld_dly_q;
  logic                  vld_q;
  logic [9*DATA_WIDTH-1:0] window_q;
  logic [9*DATA_WIDTH-1:0] win_d;
  logic [1:0]            row_sel_s;
  logic                  ready_s;
  logic                  accept_s;
  logic                  rd_act_s;
  logic [NUM_LB-1:0]     wren_s;

  assign ready_s  = (fill_q < FILL_FULL);
  assign accept_s = bus.i_pixel_valid & ready_s;
  assign rd_act_s = (state_q == S_READ);

  // Write enable for the buffer currently being filled.
  always_comb begin
    wren_s = '0;
    if (accept_s) begin
      wren_s[wr_sel_q] = 1'b1;
    end else begin
      wren_s = '0;
    end
  end

  // Fill level: a concurrent write and read cancel out.
  always_comb begin
    fill_d = fill_q;
    case ({accept_s, rd_act_s})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Window mux: row0 (oldest) comes from rd_sel_dly and lands in the MSBs.
  always_comb begin
    win_d     = '0;
    row_sel_s = '0;
    for (int i = 0; i < 3; i++) begin
      row_sel_s = rd_sel_dly_q + 2'(i);
      win_d[(2 - i) * ROW_W +: ROW_W] = bus.i_lb_rdata[row_sel_s * ROW_W +: ROW_W];
    end
  end

  // Write pointer, buffer rotation and sticky overflow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_cnt_q <= '0;
      wr_sel_q <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept_s) begin
        if (wr_cnt_q == LAST_PIX) begin
          wr_cnt_q <= '0;
          wr_sel_q <= wr_sel_q + 2'd1;
        end else begin
          wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
      end
      if (bus.i_pixel_valid && !ready_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  // Read FSM: one unstalled row of RL cycles, then at least one idle cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      rd_sel_q <= 2'd0;
      rden_q   <= '0;
      intr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          intr_q <= 1'b0;
          if (fill_q >= FILL_READ) begin
            state_q  <= S_READ;
            rd_cnt_q <= '0;
            rden_q   <= rd_mask(rd_sel_q);
          end else begin
            rden_q <= '0;
          end
        end
        S_READ: begin
          if (rd_cnt_q == LAST_PIX) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
            rd_sel_q <= rd_sel_q + 2'd1;
            rden_q   <= '0;
            intr_q   <= 1'b1;
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            intr_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rden_q  <= '0;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage lags rden by two edges: one in line_buffer, one here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_sel_dly_q <= 2'd0;
      vld_dly_q    <= 1'b0;
      vld_q        <= 1'b0;
      window_q     <= '0;
    end else begin
      rd_sel_dly_q <= rd_sel_q;
      vld_dly_q    <= |rden_q;
      vld_q        <= vld_dly_q;
      if (vld_dly_q) begin
        window_q <= win_d;
      end
    end
  end

  assign bus.o_ready        = ready_s;
  assign bus.o_lb_wren      = wren_s;
  assign bus.o_lb_wdata     = bus.i_pixel_data;
  assign bus.o_lb_rden      = rden_q;
  assign bus.o_window       = window_q;
  assign bus.o_window_valid = vld_q;
  assign bus.o_intr         = intr_q;
  assign bus.o_overflow     = ovf_q;

endmodule
